// File: rtl/maze_explorer.sv
// maze_explorer: depth-first search controller for a 16x16 maze.
// It reads walls from an external synchronous RAM and uses an external
// {x,y} coordinate stack for backtracking. When `found` is reported, the
// stack holds the discovered path.
// Optional feature: define MAZE_MOVE_COUNT_EN to build the saturating
// push+pop counter on move_count. When it is undefined, move_count is tied to 0.
module maze_explorer #(
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  maze_x,
  output logic [3:0]  maze_y,
  input  logic        maze_wall,
  output logic        push,
  output logic        pop,
  output logic [3:0]  x_push,
  output logic [3:0]  y_push,
  input  logic [3:0]  x_pop,
  input  logic [3:0]  y_pop,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        no_path,
  output logic [3:0]  cur_x,
  output logic [3:0]  cur_y,
  output logic [15:0] move_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ, S_EVAL, S_PUSH, S_POP, S_POP_WAIT, S_DONE
  } state_t;

  localparam logic [3:0] SX = 4'(START_X);
  localparam logic [3:0] SY = 4'(START_Y);
  localparam logic [3:0] GX = 4'(GOAL_X);
  localparam logic [3:0] GY = 4'(GOAL_Y);
  localparam logic [7:0] START_IDX = {SY, SX};

  state_t       state_q, state_d;
  logic [255:0] visited_q, visited_d;
  logic [7:0]   depth_q, depth_d;
  logic [3:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [2:0]   dir_q, dir_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic         found_q, found_d, no_path_q, no_path_d;

  logic [3:0]   nb_x, nb_y;
  logic         nb_oob, nb_visited, at_goal;

`ifdef MAZE_MOVE_COUNT_EN
  logic [15:0]  mc_q, mc_d;
`endif

  // Neighbour for the current scan direction. Edge cells flag out-of-bounds instead of wrapping.
  always_comb begin
    nb_x   = cur_x_q;
    nb_y   = cur_y_q;
    nb_oob = 1'b0;
    case (dir_q[1:0])
      2'd0: if (cur_x_q == 4'd15) nb_oob = 1'b1; else nb_x = cur_x_q + 4'd1;
      2'd1: if (cur_y_q == 4'd15) nb_oob = 1'b1; else nb_y = cur_y_q + 4'd1;
      2'd2: if (cur_x_q == 4'd0)  nb_oob = 1'b1; else nb_x = cur_x_q - 4'd1;
      default: if (cur_y_q == 4'd0) nb_oob = 1'b1; else nb_y = cur_y_q - 4'd1;
    endcase
    nb_visited = visited_q[{nb_y, nb_x}];
    at_goal    = (cur_x_q == GX) && (cur_y_q == GY);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      visited_q <= '0;
      depth_q   <= '0;
      cur_x_q   <= SX;
      cur_y_q   <= SY;
      dir_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      no_path_q <= 1'b0;
`ifdef MAZE_MOVE_COUNT_EN
      mc_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      visited_q <= visited_d;
      depth_q   <= depth_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
      no_path_q <= no_path_d;
`ifdef MAZE_MOVE_COUNT_EN
      mc_q      <= mc_d;
`endif
    end
  end

  // Next-state logic for the DFS walk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_CHECK;
      S_CHECK: begin
        if (at_goal)                    state_d = S_DONE;
        else if (dir_q == 3'd4)         state_d = (depth_q != 8'd0) ? S_POP : S_DONE;
        else if (nb_oob || nb_visited)  state_d = S_CHECK;
        else                            state_d = S_READ;
      end
      S_READ:     state_d = S_EVAL;
      S_EVAL:     state_d = maze_wall ? S_CHECK : S_PUSH;
      S_PUSH:     state_d = S_CHECK;
      S_POP:      state_d = S_POP_WAIT;
      S_POP_WAIT: state_d = S_CHECK;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath updates: visited map, position, depth, scan direction and status flags.
  always_comb begin
    visited_d = visited_q;
    depth_d   = depth_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    dir_d     = dir_q;
    busy_d    = busy_q;
    done_d    = done_q;
    found_d   = found_q;
    no_path_d = no_path_q;
`ifdef MAZE_MOVE_COUNT_EN
    mc_d      = mc_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        visited_d            = '0;
        visited_d[START_IDX] = 1'b1;   // start cell is entered without a wall lookup
        depth_d   = '0;
        cur_x_d   = SX;
        cur_y_d   = SY;
        dir_d     = '0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        found_d   = 1'b0;
        no_path_d = 1'b0;
`ifdef MAZE_MOVE_COUNT_EN
        mc_d      = '0;
`endif
      end
      S_CHECK: begin
        if (at_goal) begin
          found_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (dir_q == 3'd4) begin
          if (depth_q == 8'd0) begin
            no_path_d = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end
        end else if (nb_oob || nb_visited) begin
          dir_d = dir_q + 3'd1;
        end
      end
      S_EVAL: if (maze_wall) dir_d = dir_q + 3'd1;
      S_PUSH: begin
        cur_x_d                 = nb_x;
        cur_y_d                 = nb_y;
        visited_d[{nb_y, nb_x}] = 1'b1;
        depth_d                 = depth_q + 8'd1;
        dir_d                   = '0;
`ifdef MAZE_MOVE_COUNT_EN
        if (mc_q != 16'hFFFF) mc_d = mc_q + 16'd1;
`endif
      end
`ifdef MAZE_MOVE_COUNT_EN
      S_POP: if (mc_q != 16'hFFFF) mc_d = mc_q + 16'd1;
`endif
      S_POP_WAIT: begin
        // Visited cells are never re-entered, so rescanning from dir 0 is safe.
        cur_x_d = x_pop;
        cur_y_d = y_pop;
        depth_d = depth_q - 8'd1;
        dir_d   = '0;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the state and registers. The strobes are mutually exclusive by state.
  always_comb begin
    push    = (state_q == S_PUSH);
    pop     = (state_q == S_POP);
    x_push  = (state_q == S_PUSH) ? cur_x_q : 4'd0;
    y_push  = (state_q == S_PUSH) ? cur_y_q : 4'd0;
    maze_x  = (state_q == S_READ) ? nb_x : 4'd0;
    maze_y  = (state_q == S_READ) ? nb_y : 4'd0;
    busy    = busy_q;
    done    = done_q;
    found   = found_q;
    no_path = no_path_q;
    cur_x   = cur_x_q;
    cur_y   = cur_y_q;
  end

`ifdef MAZE_MOVE_COUNT_EN
  assign move_count = mc_q;
`else
  assign move_count = 16'd0;
`endif

endmodule

// File: tb/tb_maze_explorer.sv
// tb_maze_explorer: directed tests for maze_explorer with a scoreboard.
// Stimulus queues the expected push/pop sequence. A negedge monitor
// compares each strobe as it appears and checks that every popped
// coordinate is restored into cur.
module tb_maze_explorer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [3:0]  maze_x, maze_y;
  logic        maze_wall = 1'b0;
  logic        push, pop;
  logic [3:0]  x_push, y_push;
  logic [3:0]  x_pop = 4'd0, y_pop = 4'd0;
  logic        busy, done, found, no_path;
  logic [3:0]  cur_x, cur_y;
  logic [15:0] move_count;

  // second instance: START == GOAL == (5,5), every cell a wall
  logic        start_2;
  logic [3:0]  maze_x_2, maze_y_2;
  logic        maze_wall_2 = 1'b1;
  logic        push_2, pop_2;
  logic [3:0]  x_push_2, y_push_2;
  logic [3:0]  x_pop_2 = 4'd0, y_pop_2 = 4'd0;
  logic        busy_2, done_2, found_2, no_path_2;
  logic [3:0]  cur_x_2, cur_y_2;
  logic [15:0] move_count_2;

  maze_explorer dut (
    .clk(clk), .rst(rst), .start(start),
    .maze_x(maze_x), .maze_y(maze_y), .maze_wall(maze_wall),
    .push(push), .pop(pop), .x_push(x_push), .y_push(y_push),
    .x_pop(x_pop), .y_pop(y_pop),
    .busy(busy), .done(done), .found(found), .no_path(no_path),
    .cur_x(cur_x), .cur_y(cur_y), .move_count(move_count)
  );

  maze_explorer #(.START_X(5), .START_Y(5), .GOAL_X(5), .GOAL_Y(5)) dut_sg (
    .clk(clk), .rst(rst), .start(start_2),
    .maze_x(maze_x_2), .maze_y(maze_y_2), .maze_wall(maze_wall_2),
    .push(push_2), .pop(pop_2), .x_push(x_push_2), .y_push(y_push_2),
    .x_pop(x_pop_2), .y_pop(y_pop_2),
    .busy(busy_2), .done(done_2), .found(found_2), .no_path(no_path_2),
    .cur_x(cur_x_2), .cur_y(cur_y_2), .move_count(move_count_2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Wall RAM: data valid one cycle after the address.
  logic [255:0] walls = '0;
  always @(posedge clk) maze_wall <= walls[{maze_y, maze_x}];

  // Coordinate stack: popped data is valid one cycle after the pop cycle.
  logic [7:0] stk[$];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk.delete();
    end else begin
      if (push) stk.push_back({x_push, y_push});
      if (pop && stk.size() > 0) begin
        x_pop <= stk[stk.size()-1][7:4];
        y_pop <= stk[stk.size()-1][3:0];
        stk.pop_back();
      end
    end
  end

  // Scoreboard: entry {is_pop, x, y}.
  logic [8:0] exp_q[$];
  logic [8:0] sb_e;
  logic       sb_on    = 1'b0;
  int         pend     = 0;
  logic [7:0] pend_exp = '0;
  int         n_push   = 0;
  int         n_pop    = 0;
  int         busy_cyc = 0;
  int         n_strobe_2 = 0;

  task automatic exp_push(input int x, input int y);
    exp_q.push_back({1'b0, 4'(x), 4'(y)});
  endtask
  task automatic exp_pop(input int x, input int y);
    exp_q.push_back({1'b1, 4'(x), 4'(y)});
  endtask
  task automatic exp_open_run();
    for (int x = 0; x < 15; x++) exp_push(x, 0);
    for (int y = 0; y < 15; y++) exp_push(15, y);
  endtask

  // Monitor: compare each strobe against the scoreboard and check pop restores.
  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (push_2 || pop_2) n_strobe_2++;
    if (pend > 0) begin
      pend--;
      if (pend == 0) chk("pop_restore_cur", int'({cur_x, cur_y}), int'(pend_exp));
    end
    if (rst && (push || pop)) begin
      chk("push_pop_exclusive", int'(push && pop), 0);
      if (push) n_push++;
      if (pop)  n_pop++;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: actual strobe push=%0d pop=%0d at (%0d,%0d), required none",
                   push, pop, cur_x, cur_y);
        end else begin
          sb_e = exp_q.pop_front();
          chk("strobe_kind", int'(pop), int'(sb_e[8]));
          if (!sb_e[8]) begin
            chk("push_coord", int'({x_push, y_push}), int'(sb_e[7:0]));
          end else begin
            pend     = 2;
            pend_exp = sb_e[7:0];
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (!done && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk("done_reached", int'(done), 1);
  endtask

  task automatic set_wall(input int x, input int y);
    walls[y*16 + x] = 1'b1;
  endtask

  int exp_mc;
  int snap_cyc, snap_push, snap_pop, k, i;

  // Watchdog: never let the bench hang.
  initial begin
    #900000;
    $display("FAIL watchdog: actual still running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; start_2 = 1'b0;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_no_path", int'(no_path), 0);
    chk("rst_push", int'(push), 0);
    chk("rst_pop", int'(pop), 0);
    chk("rst_cur", int'({cur_x, cur_y}), 8'h00);
    chk("rst_move_count", int'(move_count), 0);
    chk("rst_sg_cur", int'({cur_x_2, cur_y_2}), 8'h55);
    @(negedge clk) rst = 1'b1;

    // Test 1: all-open maze, 30 pushes, goal found
    walls = '0; sb_on = 1'b1; exp_open_run();
    snap_cyc = busy_cyc;
    pulse_start();
    wait_done(2000);
    chk("open_found", int'(found), 1);
    chk("open_no_path", int'(no_path), 0);
    chk("open_busy", int'(busy), 0);
    chk("open_cur", int'({cur_x, cur_y}), 8'hFF);
    chk("open_cycles", busy_cyc - snap_cyc, 136);
`ifdef MAZE_MOVE_COUNT_EN
    exp_mc = 30;
`else
    exp_mc = 0;
`endif
    chk("open_move_count", int'(move_count), exp_mc);
    chk("open_sb_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("open_done_held", int'(done), 1);
    chk("open_found_held", int'(found), 1);

    // Test 6: extra start pulse while busy is ignored
    do_reset();
    exp_open_run();
    snap_cyc = busy_cyc;
    pulse_start();
    repeat (20) @(negedge clk);
    chk("extra_start_busy", int'(busy), 1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(2000);
    chk("extra_found", int'(found), 1);
    chk("extra_cycles", busy_cyc - snap_cyc, 136);
    chk("extra_sb_empty", exp_q.size(), 0);

    // Test 3: goal enclosed, full exploration, no path
    do_reset();
    sb_on = 1'b0; walls = '0;
    set_wall(14, 15); set_wall(15, 14);
    snap_push = n_push; snap_pop = n_pop;
    pulse_start();
    wait_done(20000);
    chk("encl_no_path", int'(no_path), 1);
    chk("encl_found", int'(found), 0);
    chk("encl_pushes", n_push - snap_push, 252);
    chk("encl_pops", n_pop - snap_pop, 252);
    chk("encl_stack_empty", stk.size(), 0);
`ifdef MAZE_MOVE_COUNT_EN
    exp_mc = 504;
`else
    exp_mc = 0;
`endif
    chk("encl_move_count", int'(move_count), exp_mc);

    // Test 4: dead-end corridor with backtracking
    do_reset();
    walls = '0; sb_on = 1'b1;
    set_wall(1, 0); set_wall(1, 1); set_wall(1, 2);
    set_wall(1, 4); set_wall(2, 4); set_wall(3, 3); set_wall(2, 2);
    exp_push(0, 0); exp_push(0, 1); exp_push(0, 2); exp_push(0, 3); exp_push(1, 3);
    exp_pop(1, 3);  exp_pop(0, 3);
    exp_push(0, 3); exp_push(0, 4); exp_push(0, 5);
    for (int x = 1; x < 15; x++) exp_push(x, 5);
    for (int y = 5; y < 15; y++) exp_push(15, y);
    snap_pop = n_pop;
    pulse_start();
    wait_done(3000);
    chk("dead_found", int'(found), 1);
    chk("dead_pops", n_pop - snap_pop, 2);
    chk("dead_sb_empty", exp_q.size(), 0);
    chk("dead_stack_depth", stk.size(), 30);

    // Test 5: reset asserted during PUSH, then a clean restart
    do_reset();
    walls = '0; sb_on = 1'b0;
    pulse_start();
    k = 0; i = 0;
    while (k < 3 && i < 200) begin
      @(negedge clk);
      i++;
      if (push) k++;
    end
    chk("mid_in_push", int'(push), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_push", int'(push), 0);
    chk("mid_rst_cur", int'({cur_x, cur_y}), 8'h00);
    @(negedge clk) rst = 1'b1;
    sb_on = 1'b1; exp_open_run();
    snap_cyc = busy_cyc;
    pulse_start();
    wait_done(2000);
    chk("restart_found", int'(found), 1);
    chk("restart_cycles", busy_cyc - snap_cyc, 136);
    chk("restart_sb_empty", exp_q.size(), 0);

    // Test 2: START == GOAL, found with no strobes, start cell entered despite walls
    sb_on = 1'b0;
    @(negedge clk) start_2 = 1'b1;
    @(negedge clk) start_2 = 1'b0;
    i = 0;
    while (!done_2 && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("sg_done", int'(done_2), 1);
    chk("sg_found", int'(found_2), 1);
    chk("sg_no_path", int'(no_path_2), 0);
    chk("sg_strobes", n_strobe_2, 0);
    chk("sg_cur", int'({cur_x_2, cur_y_2}), 8'h55);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
